// File: rtl/encrypt_pipe_ctrl_pkg.sv
// encrypt_config: shared types and limits for the encrypt pipeline controller.
package encrypt_config;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } ctrl_state_t;

   typedef struct packed {
      logic [7:0] k1;
      logic [7:0] k2;
      logic [7:0] k3;
   } key_set_t;

   // Upper bound on CREDITS; the in-flight counter is 4 bits wide.
   localparam int CTRL_CREDITS_MAX = 15;

endpackage

// File: rtl/encrypt_pipe_ctrl_credit_cnt.sv
// encrypt_credit_cnt: up/down saturating in-flight byte counter.
// A decrement while empty is dropped and latched into err_sticky.
module encrypt_credit_cnt
   import encrypt_config::*;
#(
   parameter int MAX = 4
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] cnt
);

   localparam logic [3:0] MAX4 = 4'(MAX);

   logic inc_ok;
   logic dec_ok;
   logic err_sticky;

   assign inc_ok = inc && (cnt < MAX4);
   assign dec_ok = dec && (cnt != 4'd0);

   // Count issues up and sink pops down; simultaneous inc/dec holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= 4'd0;
         err_sticky <= 1'b0;
      end else begin
         err_sticky <= err_sticky | (dec && !dec_ok);
         case ({inc_ok, dec_ok})
            2'b10:   cnt <= cnt + 4'd1;
            2'b01:   cnt <= cnt - 4'd1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/encrypt_pipe_ctrl.sv
// encrypt_pipe_ctrl: sequencing controller in front of the encrypt pipeline.
// Accepts bytes over valid/ready, issues them with the active key set and
// limits in-flight bytes with credits returned by the downstream sink.
// Optional: ENCRYPT_CTRL_ROT_EN enables key rotation and shift_amt toggling.
module encrypt_pipe_ctrl
   import encrypt_config::*;
#(
   parameter int CREDITS    = 4,
   parameter int PIPE_DEPTH = 2
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_load,
   input  logic [7:0] cfg_k1,
   input  logic [7:0] cfg_k2,
   input  logic [7:0] cfg_k3,
   input  logic [2:0] cfg_rot_freq,
   input  logic       cfg_mode,
   input  logic       stop,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       pipe_en,
   output logic [7:0] pipe_din,
   output logic [7:0] pipe_k1,
   output logic [7:0] pipe_k2,
   output logic [7:0] pipe_k3,
   output logic [2:0] pipe_rot_freq,
   output logic       pipe_mode,
   output logic       pipe_shift_en,
   output logic       pipe_shift_amt,
   input  logic       pipe_en_out,
   input  logic       out_pop,
   output logic       busy,
   output logic [3:0] credits_avail
);

   localparam logic [3:0] CRED4 = 4'(CREDITS);

   ctrl_state_t           state, state_nx;
   key_set_t              keys;
   key_set_t              pipe_k;
   logic [3:0]            in_flight;
   logic [PIPE_DEPTH-1:0] en_hist;
   logic                  xfer;
   logic                  load_acc;
   logic                  drained;

   assign credits_avail = CRED4 - in_flight;
   assign in_ready      = (state == RUN) && (credits_avail != 4'd0);
   assign xfer          = in_valid && in_ready;
   assign load_acc      = (state == IDLE) && cfg_load;
   assign busy          = (state != IDLE);
   assign pipe_shift_en = pipe_mode && ((state == RUN) || (state == DRAIN));
   assign pipe_k1       = pipe_k.k1;
   assign pipe_k2       = pipe_k.k2;
   assign pipe_k3       = pipe_k.k3;

   // Drain is complete once the sink has popped everything and no issue is
   // still travelling through the pipeline window.
   assign drained = (in_flight == 4'd0) && !pipe_en && (en_hist == '0) && !pipe_en_out;

   encrypt_credit_cnt #(.MAX(CREDITS)) u_credit (
      .clk (clk),
      .rst (rst),
      .inc (xfer),
      .dec (out_pop),
      .cnt (in_flight)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state: cfg_load only honoured in IDLE, stop only in RUN.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (cfg_load) state_nx = LOAD;
         LOAD:    state_nx = RUN;
         RUN:     if (stop) state_nx = DRAIN;
         DRAIN:   if (drained) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Session configuration latched on the accepted cfg_load edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_rot_freq <= 3'd0;
         pipe_mode     <= 1'b0;
      end else if (load_acc) begin
         pipe_rot_freq <= cfg_rot_freq;
         pipe_mode     <= cfg_mode;
      end
   end

`ifdef ENCRYPT_CTRL_ROT_EN
   logic [2:0] rot_cnt;
   logic       shift_q;
   logic       rot_hit;

   assign rot_hit = (rot_cnt == pipe_rot_freq);

   // Rotation counter and shift phase; the issued shift_amt is sampled
   // before the toggle so the triggering byte keeps the old phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rot_cnt        <= 3'd0;
         shift_q        <= 1'b0;
         pipe_shift_amt <= 1'b0;
      end else begin
         if (state == LOAD) begin
            rot_cnt <= 3'd0;
            shift_q <= 1'b0;
         end else if (xfer) begin
            rot_cnt <= rot_hit ? 3'd0 : rot_cnt + 3'd1;
            if (rot_hit) shift_q <= ~shift_q;
         end
         if (xfer) pipe_shift_amt <= shift_q;
      end
   end
`else
   assign pipe_shift_amt = 1'b0;
`endif

   // Working key set: loaded from cfg, rotated on the triggering transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          keys <= '0;
      else if (load_acc) keys <= {cfg_k1, cfg_k2, cfg_k3};
`ifdef ENCRYPT_CTRL_ROT_EN
      else if (xfer && rot_hit) keys <= {keys.k2, keys.k3, keys.k1};
`endif
   end

   // Issue stage: byte and the keys it was accepted under go out together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_en  <= 1'b0;
         pipe_din <= 8'd0;
         pipe_k   <= '0;
      end else begin
         pipe_en <= xfer;
         if (xfer) pipe_din <= in_data;
         if (load_acc)  pipe_k <= {cfg_k1, cfg_k2, cfg_k3};
         else if (xfer) pipe_k <= keys;
      end
   end

   // History of recent issues covering the pipeline latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) en_hist <= '0;
      else      en_hist <= (en_hist << 1) | PIPE_DEPTH'(pipe_en);
   end

endmodule

// File: tb/tb_encrypt_pipe_ctrl.sv
// tb_encrypt_pipe_ctrl: directed bench with a scoreboard of issued bytes.
module tb_encrypt_pipe_ctrl;

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] k1;
      logic [7:0] k2;
      logic [7:0] k3;
      logic       sa;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       cfg_load;
   logic [7:0] cfg_k1, cfg_k2, cfg_k3;
   logic [2:0] cfg_rot_freq;
   logic       cfg_mode;
   logic       stop;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       pipe_en;
   logic [7:0] pipe_din;
   logic [7:0] pipe_k1, pipe_k2, pipe_k3;
   logic [2:0] pipe_rot_freq;
   logic       pipe_mode;
   logic       pipe_shift_en;
   logic       pipe_shift_amt;
   logic       pipe_en_out;
   logic       out_pop;
   logic       busy;
   logic [3:0] credits_avail;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   en_cnt = 0;
   exp_t q[$];

   // bench model of key state and in-flight count
   logic [7:0] mk1, mk2, mk3;
   logic       msa;
   logic [2:0] mfreq;
   int         mcnt;
`ifdef ENCRYPT_CTRL_ROT_EN
   int         mrot;
`endif

   logic [1:0] en_dly;

   encrypt_pipe_ctrl #(.CREDITS(4), .PIPE_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load),
      .cfg_k1(cfg_k1), .cfg_k2(cfg_k2), .cfg_k3(cfg_k3),
      .cfg_rot_freq(cfg_rot_freq), .cfg_mode(cfg_mode), .stop(stop),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .pipe_en(pipe_en), .pipe_din(pipe_din),
      .pipe_k1(pipe_k1), .pipe_k2(pipe_k2), .pipe_k3(pipe_k3),
      .pipe_rot_freq(pipe_rot_freq), .pipe_mode(pipe_mode),
      .pipe_shift_en(pipe_shift_en), .pipe_shift_amt(pipe_shift_amt),
      .pipe_en_out(pipe_en_out), .out_pop(out_pop),
      .busy(busy), .credits_avail(credits_avail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // two-stage pipeline stand-in producing pipe_en_out
   always @(posedge clk or negedge rst) begin
      if (!rst) en_dly <= 2'b00;
      else      en_dly <= {en_dly[0], pipe_en};
   end
   assign pipe_en_out = en_dly[1];

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // compare every issued byte against the oldest scoreboard entry
   always @(negedge clk) begin
      if (rst && pipe_en) begin
         exp_t e;
         en_cnt++;
         n_chk++;
         assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL issue_unexpected observed=%0h expected=none", pipe_din);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("issue", {7'b0, pipe_din, pipe_k1, pipe_k2, pipe_k3, pipe_shift_amt}, {7'b0, e});
         end
      end
   end

   task automatic model_accept(input logic [7:0] d);
`ifdef ENCRYPT_CTRL_ROT_EN
      logic [7:0] t;
`endif
      q.push_back({d, mk1, mk2, mk3, msa});
`ifdef ENCRYPT_CTRL_ROT_EN
      if (mrot == int'(mfreq)) begin
         mrot = 0;
         t = mk1; mk1 = mk2; mk2 = mk3; mk3 = t;
         msa = ~msa;
      end else begin
         mrot++;
      end
`endif
      mcnt++;
   endtask

   // one clock: drive at negedge, update the model, wait for the next negedge
   task automatic cycle(input logic v, input logic [7:0] d, input logic pop,
                        input logic stp, input logic ld);
      in_valid = v; in_data = d; out_pop = pop; stop = stp; cfg_load = ld;
      if (v && in_ready) model_accept(d);
      if (pop && mcnt > 0) mcnt--;
      @(negedge clk);
      in_valid = 1'b0; in_data = 8'h00; out_pop = 1'b0; stop = 1'b0; cfg_load = 1'b0;
   endtask

   task automatic start_session(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input logic [2:0] f);
      cfg_k1 = a; cfg_k2 = b; cfg_k3 = c; cfg_rot_freq = f; cfg_mode = 1'b1;
      mk1 = a; mk2 = b; mk3 = c; mfreq = f; msa = 1'b0;
`ifdef ENCRYPT_CTRL_ROT_EN
      mrot = 0;
`endif
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("load_busy", busy, 1);
      chk("load_ready", in_ready, 0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("run_ready", in_ready, 1);
      chk("run_shift_en", pipe_shift_en, 1);
      chk("run_rot_freq", pipe_rot_freq, mfreq);
      chk("run_mode", pipe_mode, 1);
      chk("run_k1", pipe_k1, a);
   endtask

   initial begin
      rst = 1'b0; cfg_load = 1'b0; cfg_k1 = 8'h00; cfg_k2 = 8'h00; cfg_k3 = 8'h00;
      cfg_rot_freq = 3'd0; cfg_mode = 1'b0; stop = 1'b0; in_valid = 1'b0;
      in_data = 8'h00; out_pop = 1'b0;
      mk1 = 8'h00; mk2 = 8'h00; mk3 = 8'h00; msa = 1'b0; mfreq = 3'd0; mcnt = 0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_credits", credits_avail, 4);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_en", pipe_en, 0);
      chk("rst_din", pipe_din, 0);
      chk("rst_keys", {pipe_k1, pipe_k2, pipe_k3}, 0);
      chk("rst_shift_en", pipe_shift_en, 0);
      chk("rst_shift_amt", pipe_shift_amt, 0);
      chk("rst_rot_freq", pipe_rot_freq, 0);
      chk("rst_mode", pipe_mode, 0);
      rst = 1'b1;
      @(negedge clk);

      // pop with nothing in flight must not underflow
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("underflow_credits", credits_avail, 4);

      // back-pressure: exactly CREDITS issues, then one per returned credit
      start_session(8'h11, 8'h22, 8'h33, 3'd7);
      en_cnt = 0;
      for (int i = 0; i < 8; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
      chk("bp_issues", en_cnt, 4);
      chk("bp_ready", in_ready, 0);
      chk("bp_credits", credits_avail, 0);
      cycle(1'b1, 8'h48, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
      chk("bp_one_more", en_cnt, 5);
      chk("bp_credits2", credits_avail, 0);

      // stop with 3 in flight; cfg_load in DRAIN is ignored
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("drain_busy", busy, 1);
      chk("drain_ready", in_ready, 0);
      cfg_k1 = 8'hAA;
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("drain_ld_busy", busy, 1);
      chk("drain_ld_k1", pipe_k1, 8'h11);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_busy2", busy, 1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_busy3", busy, 1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("drain_idle", busy, 0);
      chk("drain_shift_en", pipe_shift_en, 0);
      chk("drain_credits", credits_avail, 4);

      // key rotation at rot_freq=2, checked through the scoreboard
      start_session(8'h11, 8'h22, 8'h33, 3'd2);
      for (int i = 0; i < 7; i++) cycle(1'b1, 8'h60 + 8'(i), (i != 0), 1'b0, 1'b0);
      chk("rot_credits", credits_avail, 3);

      // simultaneous transfer and pop at credits_avail=1
      cycle(1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
      chk("sim_pre_credits", credits_avail, 1);
      cycle(1'b1, 8'h72, 1'b1, 1'b0, 1'b0);
      chk("sim_credits", credits_avail, 1);
      chk("sim_en", pipe_en, 1);

      // asynchronous reset with 2 in flight
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_credits", credits_avail, 2);
      #2 rst = 1'b0;
      #1;
      chk("arst_credits", credits_avail, 4);
      chk("arst_busy", busy, 0);
      chk("arst_ready", in_ready, 0);
      chk("arst_en", pipe_en, 0);
      chk("arst_din", pipe_din, 0);
      chk("arst_keys", {pipe_k1, pipe_k2, pipe_k3}, 0);
      chk("arst_mode", pipe_mode, 0);
      chk("arst_shift_en", pipe_shift_en, 0);
      q.delete();
      mcnt = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // rot_freq=0: rotates each byte when enabled, fixed keys otherwise
      start_session(8'h11, 8'h22, 8'h33, 3'd0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'h80 + 8'(i), (i != 0), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 20 && busy; n++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("final_idle", busy, 0);
      chk("final_credits", credits_avail, 4);
      chk("scoreboard_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
